// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port framebuffer BRAM arbiter: video scan-out, clear engine, pixel writer
//
// Purpose: owns the one BRAM port. Video fetches (issued two pixels ahead of
// hpos) always win; the clear-screen engine and the external writer share the
// remaining cycles, with the clear pass taking precedence over the writer.
//
// Ports:
//   clk, reset        pixel clock, synchronous active-low reset
//   hpos, vpos        current beam position from the sync generator
//   wr_valid/addr/data, wr_ready
//                     external pixel writer; a transfer happens on wr_valid & wr_ready
//   clr_start, clr_color, clr_busy, clr_done
//                     clear-screen control; color sampled on an accepted start
//   bram_addr/we/wdata  combinational BRAM request
//   bram_rdata        BRAM read data, one cycle after the address
//   pixel_out         registered pixel aligned to the current hpos/vpos
`timescale 1ns/1ps
module vram_arbiter #(
  parameter int H_DISPLAY   = 640,
  parameter int V_DISPLAY   = 480,
  parameter int H_MAX       = 799,
  parameter int V_MAX       = 524,
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       hpos,
  input  logic [10:0]       vpos,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic [DATA_W-1:0] pixel_out
);

  localparam logic [10:0]       H_MAX_C  = 11'(H_MAX);
  localparam logic [10:0]       V_MAX_C  = 11'(V_MAX);
  localparam logic [10:0]       H_DISP_C = 11'(H_DISPLAY);
  localparam logic [10:0]       V_DISP_C = 11'(V_DISPLAY);
  localparam logic [ADDR_W-1:0] LAST_C   = ADDR_W'(FB_W * FB_H - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0] clr_color_q, clr_color_d;
  logic [DATA_W-1:0] pixel_q, pixel_d;
  logic              clr_done_q, clr_done_d;

  // Lookahead position: the fetch issued now lands in pixel_out two pixels later.
  logic [11:0]       hp2;
  logic              nx_wrap;
  logic [10:0]       nx, ny;
  logic              vslot;
  logic [ADDR_W-1:0] vaddr;

  always_comb begin
    hp2     = {1'b0, hpos} + 12'd2;
    nx_wrap = hp2 > {1'b0, H_MAX_C};
    nx      = nx_wrap ? 11'(hp2 - {1'b0, H_MAX_C} - 12'd1) : hp2[10:0];
    if (nx_wrap) ny = (vpos == V_MAX_C) ? 11'd0 : vpos + 11'd1;
    else         ny = vpos;
    vslot = (nx < H_DISP_C) && (ny < V_DISP_C) && (nx[SCALE_SHIFT-1:0] == '0);
    vaddr = ADDR_W'(ny >> SCALE_SHIFT) * ADDR_W'(FB_W) + ADDR_W'(nx >> SCALE_SHIFT);
  end

  // Position the beam reaches at the next edge; pixel_out is loaded for that position.
  logic [10:0] hn, vn;
  logic        vis_n;

  always_comb begin
    hn = (hpos == H_MAX_C) ? 11'd0 : hpos + 11'd1;
    if (hpos == H_MAX_C) vn = (vpos == V_MAX_C) ? 11'd0 : vpos + 11'd1;
    else                 vn = vpos;
    vis_n = (hn < H_DISP_C) && (vn < V_DISP_C);
    pixel_d = pixel_q;
    if (!vis_n)                              pixel_d = '0;
    else if (hn[SCALE_SHIFT-1:0] == '0)      pixel_d = bram_rdata;
  end

  // Port grant: video, then clear, then writer. Everything is forced off in reset.
  always_comb begin
    bram_addr  = '0;
    bram_we    = 1'b0;
    bram_wdata = '0;
    wr_ready   = 1'b0;
    if (reset) begin
      if (vslot) begin
        bram_addr = vaddr;
      end else if (state_q == CLEAR) begin
        bram_addr  = clr_addr_q;
        bram_we    = 1'b1;
        bram_wdata = clr_color_q;
      end else begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          bram_addr  = wr_addr;
          bram_we    = 1'b1;
          bram_wdata = wr_data;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    clr_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d     = CLEAR;
          clr_color_d = clr_color;
          clr_addr_d  = '0;
        end
      end
      CLEAR: begin
        // Clear only advances in cycles it actually owns the port.
        if (!vslot) begin
          if (clr_addr_q == LAST_C) begin
            state_d    = IDLE;
            clr_addr_d = '0;
            clr_done_d = 1'b1;
          end else begin
            clr_addr_d = clr_addr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    clr_color_q <= clr_color_d;
    if (!reset) begin
      state_q    <= IDLE;
      clr_addr_q <= '0;
      pixel_q    <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      pixel_q    <= pixel_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign clr_busy  = (state_q == CLEAR);
  assign clr_done  = clr_done_q;
  assign pixel_out = pixel_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter with a behavioural BRAM and reference model
`timescale 1ns/1ps
module tb_vram_arbiter;

  localparam int FB_SIZE = 19200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [10:0] hpos, vpos;
  logic        wr_valid;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        clr_start;
  logic [7:0]  clr_color;
  logic        clr_busy, clr_done;
  logic [14:0] bram_addr;
  logic        bram_we;
  logic [7:0]  bram_wdata, bram_rdata, pixel_out;

  vram_arbiter dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata), .pixel_out(pixel_out)
  );

  function automatic logic [7:0] init_val(int i);
    if (i == 0) return 8'h5A;
    return 8'((i * 37) ^ (i >> 5) ^ 165);
  endfunction

  // Synchronous-read BRAM driven by the DUT port.
  logic [7:0] bram_mem [0:32767];
  logic       bram_init;
  always @(posedge clk) begin
    if (bram_init) begin
      for (int i = 0; i < 32768; i++) bram_mem[i] <= init_val(i);
    end else begin
      if (bram_we) bram_mem[bram_addr] <= bram_wdata;
      bram_rdata <= bram_mem[bram_addr];
    end
  end

  typedef struct {
    logic        chk_regs;
    logic        chk_pix;
    logic [14:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic        ready;
    logic        busy;
    logic        done;
    logic [7:0]  pix;
    int          h;
    int          v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  logic [7:0] ref_mem [0:32767];
  bit         ref_clearing, ref_done, ref_regs_known, ref_pix_known;
  int         ref_idx;
  logic [7:0] ref_color, ref_pix;
  int         p1_h = -10, p1_v = -10, p2_h = -20, p2_v = -20;
  bit         p1_rst = 1'b1, p1_rdok, p2_rdok;
  logic [7:0] p1_rdval, p2_rdval;
  int         cur_h, cur_v;

  function automatic bit visible(int h, int v);
    return (h < 640) && (v < 480);
  endfunction
  function automatic int succ_h(int h);
    return (h == 799) ? 0 : h + 1;
  endfunction
  function automatic int succ_v(int h, int v);
    return (h == 799) ? ((v + 1) % 525) : v;
  endfunction

  task automatic adv();
    int h;
    h = cur_h;
    cur_h = succ_h(h);
    cur_v = succ_v(h, cur_v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at h=%0d v=%0d: got %0h expected %0h", name, cur_h, cur_v, act, exp);
    end
  endtask

  // One clock cycle at position (cur_h, cur_v): drive inputs, push the expected outputs.
  task automatic tick(input bit rst, input bit wv, input int wa, input int wd, input bit cs, input int cc);
    exp_t       e;
    int         nx, ny, vaddr;
    bit         vslot;
    logic [7:0] rdval;
    @(posedge clk);
    #1;
    // pixel register after the edge just taken
    if (!p1_rst) begin
      ref_pix = 8'h00; ref_pix_known = 1'b1;
    end else if (!(cur_h == succ_h(p1_h) && cur_v == succ_v(p1_h, p1_v))) begin
      ref_pix_known = 1'b0;
    end else if (!visible(cur_h, cur_v)) begin
      ref_pix = 8'h00; ref_pix_known = 1'b1;
    end else if (cur_h % 4 == 0) begin
      if (p1_h == succ_h(p2_h) && p1_v == succ_v(p2_h, p2_v) && p2_rdok) begin
        ref_pix = p2_rdval; ref_pix_known = 1'b1;
      end else begin
        ref_pix_known = 1'b0;
      end
    end

    reset     = rst;
    hpos      = 11'(cur_h);
    vpos      = 11'(cur_v);
    wr_valid  = wv;
    wr_addr   = 15'(wa);
    wr_data   = 8'(wd);
    clr_start = cs;
    clr_color = 8'(cc);

    nx    = (cur_h + 2) % 800;
    ny    = (cur_h + 2 > 799) ? (cur_v + 1) % 525 : cur_v;
    vslot = (nx < 640) && (ny < 480) && (nx % 4 == 0);
    vaddr = ((ny / 4) * 160 + nx / 4) % 32768;
    rdval = ref_mem[vaddr];

    e.chk_regs = ref_regs_known;
    e.chk_pix  = ref_pix_known;
    e.busy     = ref_clearing;
    e.done     = ref_done;
    e.pix      = ref_pix;
    e.h        = cur_h;
    e.v        = cur_v;
    e.addr     = '0;
    e.we       = 1'b0;
    e.wdata    = '0;
    e.ready    = 1'b0;
    if (rst) begin
      if (vslot) begin
        e.addr = 15'(vaddr);
      end else if (ref_clearing) begin
        e.addr = 15'(ref_idx); e.we = 1'b1; e.wdata = ref_color;
      end else begin
        e.ready = 1'b1;
        if (wv) begin e.addr = 15'(wa); e.we = 1'b1; e.wdata = 8'(wd); end
      end
    end
    sb.push_back(e);

    // state after the coming edge
    if (!rst) begin
      ref_clearing = 1'b0; ref_idx = 0; ref_done = 1'b0; ref_regs_known = 1'b1;
    end else begin
      ref_done = 1'b0;
      if (ref_clearing) begin
        if (!vslot) begin
          ref_mem[ref_idx] = ref_color;
          if (ref_idx == FB_SIZE - 1) begin
            ref_clearing = 1'b0; ref_done = 1'b1; ref_idx = 0;
          end else begin
            ref_idx++;
          end
        end
      end else begin
        if (!vslot && wv) ref_mem[wa] = 8'(wd);
        if (cs) begin ref_clearing = 1'b1; ref_color = 8'(cc); ref_idx = 0; end
      end
    end

    p2_h = p1_h; p2_v = p1_v; p2_rdok = p1_rdok; p2_rdval = p1_rdval;
    p1_h = cur_h; p1_v = cur_v; p1_rst = rst; p1_rdok = rst && vslot; p1_rdval = rdval;
  endtask

  task automatic run_random(input int n, input int wv_pct);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, ($urandom_range(99) < 32'(wv_pct)), int'($urandom_range(FB_SIZE - 1, 100)),
           int'($urandom_range(255)), 1'b0, 0);
      adv();
    end
  endtask

  // Monitor: compares every presented cycle against the scoreboard.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      bit   ok;
      e  = sb.pop_front();
      ok = (bram_addr === e.addr) && (bram_we === e.we) && (wr_ready === e.ready) &&
           (!e.we || bram_wdata === e.wdata) &&
           (!e.chk_regs || (clr_busy === e.busy && clr_done === e.done)) &&
           (!e.chk_pix || pixel_out === e.pix);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL cycle h=%0d v=%0d: got addr=%0d we=%0b wdata=%0h ready=%0b busy=%0b done=%0b pix=%0h; want addr=%0d we=%0b wdata=%0h ready=%0b busy=%0b done=%0b pix=%0h (regs %0b pix %0b)",
                 e.h, e.v, bram_addr, bram_we, bram_wdata, wr_ready, clr_busy, clr_done, pixel_out,
                 e.addr, e.we, e.wdata, e.ready, e.busy, e.done, e.pix, e.chk_regs, e.chk_pix);
      end
    end
  end

  initial begin
    int done_cnt, clr_wr_cnt;
    reset = 1'b0; hpos = '0; vpos = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clr_start = 1'b0; clr_color = '0;
    ref_clearing = 1'b0; ref_done = 1'b0; ref_regs_known = 1'b0; ref_pix_known = 1'b0;
    ref_idx = 0; ref_color = '0; ref_pix = '0; p1_rdok = 1'b0; p2_rdok = 1'b0;
    p1_rdval = '0; p2_rdval = '0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = init_val(i);
    bram_init = 1'b1;
    @(posedge clk);
    #1 bram_init = 1'b0;

    // Power-on reset with a writer pushing: port must stay closed.
    cur_h = 0; cur_v = 0;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1, 7, 8'h33, 1'b0, 0);
      #2;
      check("reset_we", 32'(bram_we), 32'd0);
      check("reset_ready", 32'(wr_ready), 32'd0);
      adv();
    end
    run_random(20, 50);

    // Frame wrap: fetch for (0,0) issued at hpos 798 of the last line.
    cur_h = 790; cur_v = 524;
    for (int i = 0; i < 31; i++) begin
      tick(1'b1, ($urandom_range(1) == 1), int'($urandom_range(FB_SIZE - 1, 100)),
           int'($urandom_range(255)), 1'b0, 0);
      #2;
      if (cur_h == 798) begin
        check("wrap_addr", 32'(bram_addr), 32'd0);
        check("wrap_we", 32'(bram_we), 32'd0);
      end
      if (cur_v == 0 && cur_h < 4) check("pixel_addr0", 32'(pixel_out), 32'h5A);
      adv();
    end

    // Video address on line 9 with the writer held valid.
    cur_h = 0; cur_v = 9;
    for (int i = 0; i < 41; i++) begin
      tick(1'b1, 1'b1, int'($urandom_range(FB_SIZE - 1, 100)), int'($urandom_range(255)), 1'b0, 0);
      #2;
      if (cur_h == 6) check("video_addr", 32'(bram_addr), 32'd322);
      check("wr_ready_video", 32'(wr_ready), (cur_h % 4 == 2) ? 32'd0 : 32'd1);
      adv();
    end

    // Vertical blanking: every valid cycle is a write.
    cur_h = 100; cur_v = 500;
    tick(1'b1, 1'b1, 7, 8'h11, 1'b0, 0);
    #2; check("blank_addr7", 32'(bram_addr), 32'd7); check("blank_we7", 32'(bram_we), 32'd1);
    adv();
    tick(1'b1, 1'b1, 8, 8'h22, 1'b0, 0);
    #2; check("blank_addr8", 32'(bram_addr), 32'd8); check("blank_we8", 32'(bram_we), 32'd1);
    adv();
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b1, int'($urandom_range(FB_SIZE - 1, 100)), int'($urandom_range(255)), 1'b0, 0);
      #2; check("blank_we", 32'(bram_we), 32'd1);
      adv();
    end

    // Readback of addresses 7 and 8 through scan-out of line 0.
    cur_h = 795; cur_v = 524;
    for (int i = 0; i < 45; i++) begin
      tick(1'b1, ($urandom_range(1) == 1), int'($urandom_range(FB_SIZE - 1, 100)),
           int'($urandom_range(255)), 1'b0, 0);
      #2;
      if (cur_v == 0 && cur_h == 29) check("readback7", 32'(pixel_out), 32'h11);
      if (cur_v == 0 && cur_h == 33) check("readback8", 32'(pixel_out), 32'h22);
      adv();
    end

    // Full clear from the start of vertical blanking, with a stray start mid-pass.
    cur_h = 0; cur_v = 480;
    tick(1'b1, 1'b0, 0, 0, 1'b1, 8'h03);
    adv();
    done_cnt = 0; clr_wr_cnt = 0;
    for (int i = 0; i < FB_SIZE + 4; i++) begin
      tick(1'b1, ($urandom_range(1) == 1), int'($urandom_range(FB_SIZE - 1, 100)),
           int'($urandom_range(255)), (i == 5000), 8'h44);
      #2;
      if (clr_done === 1'b1) done_cnt++;
      if (i < FB_SIZE && bram_we === 1'b1 && bram_wdata === 8'h03) clr_wr_cnt++;
      adv();
    end
    check("clr_done_count", 32'(done_cnt), 32'd1);
    check("clr_write_count", 32'(clr_wr_cnt), 32'(FB_SIZE));
    check("clr_busy_after", 32'(clr_busy), 32'd0);

    cur_h = 790; cur_v = 524;
    for (int i = 0; i < 60; i++) begin
      tick(1'b1, 1'b0, 0, 0, 1'b0, 0);
      #2;
      if (cur_v == 0 && cur_h == 50) check("cleared_pixel", 32'(pixel_out), 32'h03);
      adv();
    end

    // Start and writer transfer in the same cycle.
    cur_h = 0; cur_v = 490;
    tick(1'b1, 1'b1, 5, 8'h77, 1'b1, 8'h0C);
    #2;
    check("simul_we", 32'(bram_we), 32'd1);
    check("simul_addr", 32'(bram_addr), 32'd5);
    check("simul_wdata", 32'(bram_wdata), 32'h77);
    adv();
    tick(1'b1, 1'b0, 0, 0, 1'b0, 0);
    #2;
    check("simul_clr_addr", 32'(bram_addr), 32'd0);
    check("simul_clr_wdata", 32'(bram_wdata), 32'h0C);
    check("simul_clr_busy", 32'(clr_busy), 32'd1);
    adv();
    run_random(1000, 50);

    // Reset in the middle of the clear pass.
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1, int'($urandom_range(FB_SIZE - 1, 100)), int'($urandom_range(255)), 1'b0, 0);
      #2;
      check("midclr_rst_we", 32'(bram_we), 32'd0);
      check("midclr_rst_ready", 32'(wr_ready), 32'd0);
      check("midclr_rst_addr", 32'(bram_addr), 32'd0);
      if (k > 0) begin
        check("midclr_rst_busy", 32'(clr_busy), 32'd0);
        check("midclr_rst_pix", 32'(pixel_out), 32'd0);
      end
      adv();
    end
    tick(1'b1, 1'b1, 200, 8'h99, 1'b0, 0);
    #2;
    check("post_rst_busy", 32'(clr_busy), 32'd0);
    check("post_rst_ready", 32'(wr_ready), 32'd1);
    check("post_rst_addr", 32'(bram_addr), 32'd200);
    adv();
    for (int i = 0; i < 50; i++) begin
      tick(1'b1, 1'b0, 0, 0, 1'b0, 0);
      #2; check("no_resume_we", 32'(bram_we), 32'd0);
      adv();
    end

    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
